// File: rtl/fpr_cdb_arbiter.sv
// fpr_cdb_arbiter
// ---------------
// Owns the FPR common data bus. The FP reservation stations (fadd, fmul and
// the shared fdiv/fsqrt station) request dispatch here. Every granted op is
// tracked through a fixed-latency slot pipeline, so that the cycle its core
// result becomes valid is known in advance. Grants are only given when the
// op's landing slot is unclaimed, which keeps two results from ever reaching
// the CDB in the same cycle. When an op reaches the head of the pipeline,
// the matching core output is captured and broadcast on the CDB.
//
// Ports
//   clk                      clock
//   reset                    synchronous, active-low reset (reset_n)
//   fadd_req_valid/_ready    fadd station request / grant (ready is combinational)
//   fadd_tag, result_fadd    ROB tag of dispatching fadd entry, fadd core output
//   fmul_*                   same for the fmul station
//   fdiv_fsqrt_req_valid     fdiv/fsqrt station request
//   fdiv_fsqrt_req_is_fsqrt  1 = fsqrt latency/result, 0 = fdiv
//   fdiv_fsqrt_req_ready     grant to the fdiv/fsqrt station
//   fdiv_fsqrt_tag           ROB tag of dispatching fdiv/fsqrt entry
//   result_fdiv/result_fsqrt fdiv and fsqrt core outputs
//   fpr_cdb_valid/tag/data   registered CDB broadcast
//
// Ready priority when two units land on the same slot:
// fdiv_fsqrt > fmul > fadd. A unit's ready never looks at its own request.

module fpr_cdb_arbiter #(
    parameter int ROB_WIDTH = 4,
    parameter int LAT_FADD  = 3,
    parameter int LAT_FMUL  = 3,
    parameter int LAT_FDIV  = 12,
    parameter int LAT_FSQRT = 9,
    parameter int MAX_LAT   = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,

    input  logic                 fadd_req_valid,
    output logic                 fadd_req_ready,
    input  logic [ROB_WIDTH-1:0] fadd_tag,
    input  logic [31:0]          result_fadd,

    input  logic                 fmul_req_valid,
    output logic                 fmul_req_ready,
    input  logic [ROB_WIDTH-1:0] fmul_tag,
    input  logic [31:0]          result_fmul,

    input  logic                 fdiv_fsqrt_req_valid,
    input  logic                 fdiv_fsqrt_req_is_fsqrt,
    output logic                 fdiv_fsqrt_req_ready,
    input  logic [ROB_WIDTH-1:0] fdiv_fsqrt_tag,
    input  logic [31:0]          result_fdiv,
    input  logic [31:0]          result_fsqrt,

    output logic                 fpr_cdb_valid,
    output logic [ROB_WIDTH-1:0] fpr_cdb_tag,
    output logic [31:0]          fpr_cdb_data
);

    // Width of a slot-pipeline index (p[0..MAX_LAT-1]).
    localparam int PW = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;

    typedef enum logic [1:0] {
        SRC_FADD  = 2'd0,
        SRC_FMUL  = 2'd1,
        SRC_FDIV  = 2'd2,
        SRC_FSQRT = 2'd3
    } src_e;

    // Slot pipeline state and its next-state image.
    logic                 p_valid_r [MAX_LAT];
    logic [ROB_WIDTH-1:0] p_tag_r   [MAX_LAT];
    src_e                 p_src_r   [MAX_LAT];

    logic                 p_valid_s [MAX_LAT];
    logic [ROB_WIDTH-1:0] p_tag_s   [MAX_LAT];
    src_e                 p_src_s   [MAX_LAT];

    // Pipeline contents after the plain shift, before any grant writes.
    logic                 sh_valid_s [MAX_LAT];
    logic [ROB_WIDTH-1:0] sh_tag_s   [MAX_LAT];
    src_e                 sh_src_s   [MAX_LAT];

    // free_s[k] means latency L = k+1 can be granted: whatever sits in p[L]
    // would otherwise shift into p[L-1], the index the grant writes.
    logic [MAX_LAT-1:0]   free_s;

    logic [PW-1:0]        div_idx_s;
    src_e                 div_src_s;
    logic                 div_ready_s;
    logic                 fmul_ready_s;
    logic                 fadd_ready_s;
    logic                 div_grant_s;
    logic                 fmul_grant_s;
    logic                 fadd_grant_s;
    logic [31:0]          cdb_data_s;

    logic                 cdb_valid_r;
    logic [ROB_WIDTH-1:0] cdb_tag_r;
    logic [31:0]          cdb_data_r;

    // Slot availability per latency.
    always_comb begin
        for (int k = 0; k < MAX_LAT - 1; k++) begin
            free_s[k] = !p_valid_r[k + 1];
        end
        free_s[MAX_LAT-1] = 1'b1;
    end

    // Landing index and source for the shared fdiv/fsqrt station.
    always_comb begin
        if (fdiv_fsqrt_req_is_fsqrt) begin
            div_idx_s = PW'(LAT_FSQRT - 1);
            div_src_s = SRC_FSQRT;
        end else begin
            div_idx_s = PW'(LAT_FDIV - 1);
            div_src_s = SRC_FDIV;
        end
    end

    // Fixed-priority ready: a lower unit yields when a higher unit with a
    // live request targets the same latency slot. All grants drop in reset.
    always_comb begin
        div_ready_s  = reset_n && free_s[div_idx_s];
        fmul_ready_s = reset_n && free_s[LAT_FMUL-1]
                       && !(fdiv_fsqrt_req_valid && (div_idx_s == PW'(LAT_FMUL - 1)));
        fadd_ready_s = reset_n && free_s[LAT_FADD-1]
                       && !(fdiv_fsqrt_req_valid && (div_idx_s == PW'(LAT_FADD - 1)))
                       && !(fmul_req_valid && (LAT_FMUL == LAT_FADD));
    end

    assign div_grant_s  = fdiv_fsqrt_req_valid && div_ready_s;
    assign fmul_grant_s = fmul_req_valid && fmul_ready_s;
    assign fadd_grant_s = fadd_req_valid && fadd_ready_s;

    assign fdiv_fsqrt_req_ready = div_ready_s;
    assign fmul_req_ready       = fmul_ready_s;
    assign fadd_req_ready       = fadd_ready_s;

    // Plain one-step shift toward p[0]; the top entry empties.
    always_comb begin
        for (int i = 0; i < MAX_LAT - 1; i++) begin
            sh_valid_s[i] = p_valid_r[i + 1];
            sh_tag_s[i]   = p_tag_r[i + 1];
            sh_src_s[i]   = p_src_r[i + 1];
        end
        sh_valid_s[MAX_LAT-1] = 1'b0;
        sh_tag_s[MAX_LAT-1]   = '0;
        sh_src_s[MAX_LAT-1]   = SRC_FADD;
    end

    // Next pipeline state: grant writes override the shift. Ready logic
    // guarantees the overridden shifted entry is empty and that no two
    // grants share an index, so the chain order here is only cosmetic.
    always_comb begin
        for (int i = 0; i < MAX_LAT; i++) begin
            if (div_grant_s && (div_idx_s == PW'(i))) begin
                p_valid_s[i] = 1'b1;
                p_tag_s[i]   = fdiv_fsqrt_tag;
                p_src_s[i]   = div_src_s;
            end else if (fmul_grant_s && (i == LAT_FMUL - 1)) begin
                p_valid_s[i] = 1'b1;
                p_tag_s[i]   = fmul_tag;
                p_src_s[i]   = SRC_FMUL;
            end else if (fadd_grant_s && (i == LAT_FADD - 1)) begin
                p_valid_s[i] = 1'b1;
                p_tag_s[i]   = fadd_tag;
                p_src_s[i]   = SRC_FADD;
            end else begin
                p_valid_s[i] = sh_valid_s[i];
                p_tag_s[i]   = sh_tag_s[i];
                p_src_s[i]   = sh_src_s[i];
            end
        end
    end

    // Pick the core output belonging to the op at the pipeline head.
    always_comb begin
        case (p_src_r[0])
            SRC_FADD:  cdb_data_s = result_fadd;
            SRC_FMUL:  cdb_data_s = result_fmul;
            SRC_FDIV:  cdb_data_s = result_fdiv;
            SRC_FSQRT: cdb_data_s = result_fsqrt;
            default:   cdb_data_s = result_fadd;
        endcase
    end

    // Slot pipeline and CDB registers; reset drops all in-flight ops.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < MAX_LAT; i++) begin
                p_valid_r[i] <= 1'b0;
                p_tag_r[i]   <= '0;
                p_src_r[i]   <= SRC_FADD;
            end
            cdb_valid_r <= 1'b0;
            cdb_tag_r   <= '0;
            cdb_data_r  <= 32'h0000_0000;
        end else begin
            for (int i = 0; i < MAX_LAT; i++) begin
                p_valid_r[i] <= p_valid_s[i];
                p_tag_r[i]   <= p_tag_s[i];
                p_src_r[i]   <= p_src_s[i];
            end
            cdb_valid_r <= p_valid_r[0];
            // Tag/data only move on a real broadcast and hold otherwise.
            if (p_valid_r[0]) begin
                cdb_tag_r  <= p_tag_r[0];
                cdb_data_r <= cdb_data_s;
            end else begin
                cdb_tag_r  <= cdb_tag_r;
                cdb_data_r <= cdb_data_r;
            end
        end
    end

    assign fpr_cdb_valid = cdb_valid_r;
    assign fpr_cdb_tag   = cdb_tag_r;
    assign fpr_cdb_data  = cdb_data_r;

endmodule

// File: tb/tb_fpr_cdb_arbiter.sv
// Scoreboard bench for fpr_cdb_arbiter. Each granted request pushes the
// cycle its broadcast is due, its tag and its source; a monitor on the
// falling edge pops the matching entry and compares the CDB, and demands
// an idle CDB in every cycle where nothing is due. Core outputs are driven
// as a known function of (source, cycle) so the expected data is computed
// here rather than read back.

module tb_fpr_cdb_arbiter;

    localparam int ROB_WIDTH = 4;
    localparam int LAT_FADD  = 3;
    localparam int LAT_FMUL  = 3;
    localparam int LAT_FDIV  = 12;
    localparam int LAT_FSQRT = 9;
    localparam int MAX_LAT   = 16;

    logic                 clk;
    logic                 reset_n;
    logic                 fadd_req_valid;
    logic                 fadd_req_ready;
    logic [ROB_WIDTH-1:0] fadd_tag;
    logic [31:0]          result_fadd;
    logic                 fmul_req_valid;
    logic                 fmul_req_ready;
    logic [ROB_WIDTH-1:0] fmul_tag;
    logic [31:0]          result_fmul;
    logic                 fdiv_fsqrt_req_valid;
    logic                 fdiv_fsqrt_req_is_fsqrt;
    logic                 fdiv_fsqrt_req_ready;
    logic [ROB_WIDTH-1:0] fdiv_fsqrt_tag;
    logic [31:0]          result_fdiv;
    logic [31:0]          result_fsqrt;
    logic                 fpr_cdb_valid;
    logic [ROB_WIDTH-1:0] fpr_cdb_tag;
    logic [31:0]          fpr_cdb_data;

    fpr_cdb_arbiter #(
        .ROB_WIDTH (ROB_WIDTH),
        .LAT_FADD  (LAT_FADD),
        .LAT_FMUL  (LAT_FMUL),
        .LAT_FDIV  (LAT_FDIV),
        .LAT_FSQRT (LAT_FSQRT),
        .MAX_LAT   (MAX_LAT)
    ) dut (
        .clk                     (clk),
        .reset_n                 (reset_n),
        .fadd_req_valid          (fadd_req_valid),
        .fadd_req_ready          (fadd_req_ready),
        .fadd_tag                (fadd_tag),
        .result_fadd             (result_fadd),
        .fmul_req_valid          (fmul_req_valid),
        .fmul_req_ready          (fmul_req_ready),
        .fmul_tag                (fmul_tag),
        .result_fmul             (result_fmul),
        .fdiv_fsqrt_req_valid    (fdiv_fsqrt_req_valid),
        .fdiv_fsqrt_req_is_fsqrt (fdiv_fsqrt_req_is_fsqrt),
        .fdiv_fsqrt_req_ready    (fdiv_fsqrt_req_ready),
        .fdiv_fsqrt_tag          (fdiv_fsqrt_tag),
        .result_fdiv             (result_fdiv),
        .result_fsqrt            (result_fsqrt),
        .fpr_cdb_valid           (fpr_cdb_valid),
        .fpr_cdb_tag             (fpr_cdb_tag),
        .fpr_cdb_data            (fpr_cdb_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int                   due;
        logic [ROB_WIDTH-1:0] tag;
        int                   src;   // 0 fadd, 1 fmul, 2 fdiv, 3 fsqrt
    } exp_t;

    exp_t sb[$];
    int   cyc;
    int   n_checks;
    int   n_fail;
    bit   mon_en;

    // Core output pattern: source in the top nibble, cycle number below.
    function automatic logic [31:0] core_val(input int src, input int c);
        logic [31:0] base;
        case (src)
            0:       base = 32'h1000_0000;
            1:       base = 32'h2000_0000;
            2:       base = 32'h3000_0000;
            3:       base = 32'h4000_0000;
            default: base = 32'hF000_0000;
        endcase
        return base + 32'(c);
    endfunction

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, obs, exp, cyc);
        end
    endtask

    task automatic set_results();
        result_fadd  = core_val(0, cyc);
        result_fmul  = core_val(1, cyc);
        result_fdiv  = core_val(2, cyc);
        result_fsqrt = core_val(3, cyc);
    endtask

    task automatic advance();
        @(posedge clk);
        #1;
        cyc++;
        set_results();
    endtask

    // One cycle of requests; exp_rdy = {fdiv_fsqrt, fmul, fadd} ready
    // expected for each requesting unit. Expected grants feed the scoreboard.
    task automatic do_cycle(input logic av, input logic [3:0] at,
                            input logic mv, input logic [3:0] mt,
                            input logic dv, input logic dsq, input logic [3:0] dt,
                            input logic [2:0] exp_rdy);
        fadd_req_valid          = av;
        fadd_tag                = at;
        fmul_req_valid          = mv;
        fmul_tag                = mt;
        fdiv_fsqrt_req_valid    = dv;
        fdiv_fsqrt_req_is_fsqrt = dsq;
        fdiv_fsqrt_tag          = dt;
        @(negedge clk);
        if (av) begin
            check("fadd_ready", 32'(fadd_req_ready), 32'(exp_rdy[0]));
            if (exp_rdy[0]) sb.push_back('{due: cyc + LAT_FADD + 1, tag: at, src: 0});
        end
        if (mv) begin
            check("fmul_ready", 32'(fmul_req_ready), 32'(exp_rdy[1]));
            if (exp_rdy[1]) sb.push_back('{due: cyc + LAT_FMUL + 1, tag: mt, src: 1});
        end
        if (dv) begin
            check("div_ready", 32'(fdiv_fsqrt_req_ready), 32'(exp_rdy[2]));
            if (exp_rdy[2]) begin
                if (dsq) sb.push_back('{due: cyc + LAT_FSQRT + 1, tag: dt, src: 3});
                else     sb.push_back('{due: cyc + LAT_FDIV + 1, tag: dt, src: 2});
            end
        end
        advance();
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) do_cycle(1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 3'b000);
    endtask

    // One reset cycle with every station requesting: no grants, all
    // in-flight ops dropped, CDB registers cleared afterwards.
    task automatic reset_cycle();
        reset_n                 = 1'b0;
        fadd_req_valid          = 1'b1;
        fadd_tag                = 4'd1;
        fmul_req_valid          = 1'b1;
        fmul_tag                = 4'd2;
        fdiv_fsqrt_req_valid    = 1'b1;
        fdiv_fsqrt_req_is_fsqrt = 1'b0;
        fdiv_fsqrt_tag          = 4'd3;
        @(negedge clk);
        check("rst_fadd_ready", 32'(fadd_req_ready), 32'd0);
        check("rst_fmul_ready", 32'(fmul_req_ready), 32'd0);
        check("rst_div_ready", 32'(fdiv_fsqrt_req_ready), 32'd0);
        sb.delete();
        advance();
        reset_n              = 1'b1;
        fadd_req_valid       = 1'b0;
        fmul_req_valid       = 1'b0;
        fdiv_fsqrt_req_valid = 1'b0;
        check("rst_cdb_valid", 32'(fpr_cdb_valid), 32'd0);
        check("rst_cdb_tag", 32'(fpr_cdb_tag), 32'd0);
        check("rst_cdb_data", fpr_cdb_data, 32'd0);
    endtask

    // CDB monitor: compare against the entry due this cycle, else expect idle.
    initial begin
        forever begin : mon
            int idx;
            @(negedge clk);
            if (mon_en) begin
                idx = -1;
                foreach (sb[i]) if (sb[i].due == cyc) idx = i;
                if (idx >= 0) begin
                    check("cdb_valid", 32'(fpr_cdb_valid), 32'd1);
                    check("cdb_tag", 32'(fpr_cdb_tag), 32'(sb[idx].tag));
                    check("cdb_data", fpr_cdb_data, core_val(sb[idx].src, sb[idx].due - 1));
                    sb.delete(idx);
                end else begin
                    check("cdb_idle", 32'(fpr_cdb_valid), 32'd0);
                end
            end
        end
    end

    initial begin
        n_checks = 0;
        n_fail   = 0;
        mon_en   = 1'b0;
        cyc      = 0;
        reset_n  = 1'b0;
        fadd_req_valid = 1'b0; fadd_tag = 4'd0;
        fmul_req_valid = 1'b0; fmul_tag = 4'd0;
        fdiv_fsqrt_req_valid = 1'b0; fdiv_fsqrt_req_is_fsqrt = 1'b0; fdiv_fsqrt_tag = 4'd0;
        set_results();
        @(posedge clk);
        #1;
        set_results();
        reset_cycle();
        reset_cycle();
        mon_en = 1'b1;

        // 1: single fadd, broadcast at t+4 for exactly one cycle
        do_cycle(1'b1, 4'd5, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 3'b001);
        idle(6);

        // 2: fdiv occupies the fadd landing slot in its cycle 9
        do_cycle(1'b0, 4'd0, 1'b0, 4'd0, 1'b1, 1'b0, 4'd2, 3'b100);
        idle(8);
        do_cycle(1'b1, 4'd7, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 3'b000);
        do_cycle(1'b1, 4'd7, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 3'b001);
        idle(6);

        // 3: fmul beats fadd on the shared latency, fadd follows
        do_cycle(1'b1, 4'd1, 1'b1, 4'd3, 1'b0, 1'b0, 4'd0, 3'b010);
        do_cycle(1'b1, 4'd1, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 3'b001);
        idle(8);

        // 4: fsqrt and fadd together; fsqrt must carry result_fsqrt
        do_cycle(1'b1, 4'd6, 1'b0, 4'd0, 1'b1, 1'b1, 4'd4, 3'b101);
        idle(14);

        // 5: back-to-back fmul, tags 0..7
        for (int k = 0; k < 8; k++) do_cycle(1'b0, 4'd0, 1'b1, 4'(k), 1'b0, 1'b0, 4'd0, 3'b010);
        idle(12);

        // 6: reset mid-fdiv drops it; fadd after reset broadcasts normally
        do_cycle(1'b0, 4'd0, 1'b0, 4'd0, 1'b1, 1'b0, 4'd9, 3'b100);
        idle(4);
        reset_cycle();
        do_cycle(1'b1, 4'd11, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 3'b001);
        idle(16);

        mon_en = 1'b0;
        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
